echo_effect: RTL and testbench
==============================

# echo_effect

Audio echo (feedback delay) stage sitting between the ADC SPI front end and the DAC serializer of the pedal. It accepts one 12-bit offset-binary sample per `in_valid` strobe and mixes it with an attenuated copy of its own output from `delay_len` samples earlier. The delayed history is kept in an on-chip circular buffer. The result is emitted as a 12-bit offset-binary sample with a one-cycle `out_valid` strobe for the DAC path.

## Interface
- `ADDR_W`, default 10: buffer address width; depth is 2^ADDR_W samples.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_b`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  one-cycle strobe: `in_data` holds a new sample.
- `in_data`  in  12  ADC sample, offset binary (0x800 = zero).
- `delay_len`  in  ADDR_W  echo delay in samples, 0..2^ADDR_W−1; 0 disables the echo.
- `mix_shift`  in  2  echo attenuation: delayed sample >>> (mix_shift+1), i.e. gain 1/2..1/16.
- `bypass`  in  1  1 = output equals input (dry).
- `out_valid`  out  1  one-cycle strobe: `out_data` updated.
- `out_data`  out  12  processed sample, offset binary; holds its value between strobes.
- `busy`  out  1  high while a sample is in flight.

## Operation
- FSM states: IDLE, READ, MIX, EMIT.
  - IDLE→READ when `in_valid`=1.
  - READ→MIX, MIX→EMIT and EMIT→IDLE are unconditional.
- `busy` = (state != IDLE).
- On acceptance (IDLE and `in_valid`), register the following:
  - x = `in_data` ^ 0x800, as signed 12-bit.
  - `delay_len`, `mix_shift`, `bypass` (sampled once per sample).
  - raddr = (wr_ptr − delay_len) mod 2^ADDR_W.
- READ: synchronous buffer read at raddr. The read data is registered at the end of READ.
- MIX computes the output as follows:
  - d = buffer data if (fill ≥ delay_len_r and delay_len_r != 0), else 0.
  - sum = x + (d >>> (mix_shift_r+1)), computed at 13 bits signed.
  - y = sum saturated to [−2048, +2047].
  - If bypass_r, y = x.
  - Write y to buffer[wr_ptr]; wr_ptr increments, wrapping 2^ADDR_W−1 → 0.
  - fill increments, saturating at 2^ADDR_W−1.
- EMIT: `out_data` ← y ^ 0x800; `out_valid`=1 for this cycle only.
- `in_valid` while `busy`=1: the sample is dropped. No state, pointer or buffer change.
- Buffer RAM is not cleared by reset. fill gates stale contents, so pre-reset data is never output.

## Timing
- Reset (`reset_b`=0 at a posedge), taking effect at that edge:
  - state=IDLE, `out_valid`=0, `out_data`=0x800, `busy`=0, wr_ptr=0, fill=0.
  - Reset mid-operation aborts the in-flight sample: no `out_valid`, no buffer write counted.
- Latency: `in_valid` sampled at edge N → `out_valid` high during the cycle after edge N+3 (3-edge latency), for exactly one cycle.
- Throughput: at most one sample per 4 clocks. A new `in_valid` is accepted in IDLE only, i.e. earliest at edge N+4.
- `out_data` changes only in EMIT.
- Boundary cases:
  - delay_len = 2^ADDR_W−1 is legal.
  - raddr wraps correctly across 0.
  - Saturation is applied before the buffer write, so feedback never overflows.

## Test plan
- Reset: hold `reset_b`=0 for 2 cycles → `out_valid`=0, `out_data`=0x800, `busy`=0. Then `in_data`=0x800, delay_len=0 → `out_data`=0x800.
- Bypass/latency: `bypass`=1, `in_data`=0x123 at edge N → `out_valid` only after edge N+3 with `out_data`=0x123; `busy` high for 3 cycles.
- Impulse echo: delay_len=4, mix_shift=0; sample 0 = 0xC00, then 0x800 thereafter, one every 16 clocks. Required outputs:
  - out[0]=0xC00
  - out[4]=0xA00
  - out[8]=0x900
  - out[12]=0x880
  - all others 0x800.
- Saturation, positive: delay_len=1, mix_shift=0, constant 0xFFF → every output 0xFFF.
- Saturation, negative: same settings, constant 0x000 → every output 0x000 (no wrap).
- Fill gating/wrap: after reset, delay_len=1023, mix_shift=3, ramp input → outputs 0..1022 equal inputs exactly. out[1023] = in[1023] + (x0 >>> 4). Continue past 1024 samples to verify wr_ptr wrap.
- Drop/reset: `in_valid` 2 cycles after an accepted sample → dropped, exactly one `out_valid`. Separately, pull `reset_b` low while in MIX → no `out_valid`, and the next sample sees fill=0 (no echo).

Source files
------------

// File: rtl/echo_effect.sv
// Feedback echo stage: mixes each offset-binary input sample with an attenuated
// copy of its own output from delay_len samples earlier, held in a circular buffer.
module echo_effect #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              in_valid,
  input  logic [11:0]       in_data,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic [1:0]        mix_shift,
  input  logic              bypass,
  output logic              out_valid,
  output logic [11:0]       out_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] FULL_C = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    MIX  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t                    state_r;
  logic signed [11:0]        x_r;
  logic signed [11:0]        y_r;
  logic        [ADDR_W-1:0]  delay_len_r;
  logic        [1:0]         mix_shift_r;
  logic                      bypass_r;
  logic        [ADDR_W-1:0]  raddr_r;
  logic        [ADDR_W-1:0]  wr_ptr_r;
  logic        [ADDR_W-1:0]  fill_r;
  logic        [11:0]        rdata_r;
  logic                      out_valid_r;
  logic        [11:0]        out_data_r;
  logic        [11:0]        mem_r [0:DEPTH-1];

  logic signed [11:0]        d_s;
  logic signed [11:0]        shifted_s;
  logic signed [12:0]        sum_s;
  logic signed [11:0]        y_s;
  logic                      mem_we_s;

  // Echo mix: fill gates buffer slots not yet written since reset.
  always_comb begin
    d_s       = 12'sd0;
    shifted_s = 12'sd0;
    sum_s     = 13'sd0;
    y_s       = 12'sd0;
    if ((fill_r >= delay_len_r) && (delay_len_r != {ADDR_W{1'b0}})) begin
      d_s = $signed(rdata_r);
    end else begin
      d_s = 12'sd0;
    end
    shifted_s = d_s >>> ({1'b0, mix_shift_r} + 3'd1);
    sum_s     = {x_r[11], x_r} + {shifted_s[11], shifted_s};
    // Clamp before the buffer write so the feedback loop can never wrap.
    if (sum_s[12] != sum_s[11]) begin
      y_s = sum_s[12] ? 12'sh800 : 12'sh7FF;
    end else begin
      y_s = sum_s[11:0];
    end
    if (bypass_r) begin
      y_s = x_r;
    end else begin
      y_s = y_s;
    end
  end

  assign mem_we_s = reset_b && (state_r == MIX);

  // History buffer, not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[wr_ptr_r] <= $unsigned(y_s);
    end
    if (state_r == READ) begin
      rdata_r <= mem_r[raddr_r];
    end
  end

  // Sample sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_data_r  <= 12'h800;
      wr_ptr_r    <= {ADDR_W{1'b0}};
      fill_r      <= {ADDR_W{1'b0}};
      x_r         <= 12'sd0;
      y_r         <= 12'sd0;
      delay_len_r <= {ADDR_W{1'b0}};
      mix_shift_r <= 2'd0;
      bypass_r    <= 1'b0;
      raddr_r     <= {ADDR_W{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r         <= $signed(in_data ^ 12'h800);
            delay_len_r <= delay_len;
            mix_shift_r <= mix_shift;
            bypass_r    <= bypass;
            raddr_r     <= wr_ptr_r - delay_len;
            state_r     <= READ;
          end
        end
        READ: begin
          state_r <= MIX;
        end
        MIX: begin
          y_r      <= y_s;
          wr_ptr_r <= wr_ptr_r + ONE_C;
          if (fill_r != FULL_C) begin
            fill_r <= fill_r + ONE_C;
          end
          state_r  <= EMIT;
        end
        EMIT: begin
          out_data_r  <= $unsigned(y_r) ^ 12'h800;
          out_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_echo_effect.sv
// Directed self-checking bench for echo_effect.
module tb_echo_effect;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = 12'h800;
  logic [9:0]  delay_len = 10'd0;
  logic [1:0]  mix_shift = 2'd0;
  logic        bypass = 1'b0;
  logic        out_valid;
  logic [11:0] out_data;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  echo_effect #(.ADDR_W(10)) dut (
    .clk(clk), .reset_b(reset_b), .in_valid(in_valid), .in_data(in_data),
    .delay_len(delay_len), .mix_shift(mix_shift), .bypass(bypass),
    .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset_b = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_b = 1'b1;
  endtask

  // Drives one sample and waits (bounded) for its output strobe.
  task automatic run_sample(input logic [11:0] din, output logic [11:0] dout, output bit got);
    in_data = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    got = 1'b0;
    dout = 12'h000;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        dout = out_data;
      end
    end
  endtask

  task automatic test_reset();
    logic [11:0] d;
    bit got;
    reset_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_data !== 12'h800) begin tests_failed++; $display("FAIL reset_out_data got %h want 800", out_data); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    reset_b = 1'b1;
    delay_len = 10'd0; bypass = 1'b0; mix_shift = 2'd0;
    run_sample(12'h800, d, got);
    tests_run++;
    if (!got || d !== 12'h800) begin tests_failed++; $display("FAIL reset_first_sample got %h (strobe %0d) want 800", d, got); end
  endtask

  task automatic test_bypass_latency();
    logic [4:0] exp_busy = 5'b00111;
    logic [4:0] exp_ov   = 5'b01000;
    do_reset();
    bypass = 1'b1; delay_len = 10'd0;
    in_data = 12'h123;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (busy !== exp_busy[k] || out_valid !== exp_ov[k]) begin
        tests_failed++;
        $display("FAIL bypass_cycle%0d got busy=%b ov=%b want busy=%b ov=%b", k, busy, out_valid, exp_busy[k], exp_ov[k]);
      end
      if (k == 3) begin
        tests_run++;
        if (out_data !== 12'h123) begin tests_failed++; $display("FAIL bypass_data got %h want 123", out_data); end
      end
      @(posedge clk); #1;
    end
    bypass = 1'b0;
  endtask

  task automatic test_impulse();
    logic [11:0] d, exp;
    bit got;
    do_reset();
    delay_len = 10'd4; mix_shift = 2'd0; bypass = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_sample((i == 0) ? 12'hC00 : 12'h800, d, got);
      case (i)
        0:       exp = 12'hC00;
        4:       exp = 12'hA00;
        8:       exp = 12'h900;
        12:      exp = 12'h880;
        default: exp = 12'h800;
      endcase
      tests_run++;
      if (!got || d !== exp) begin tests_failed++; $display("FAIL impulse_out%0d got %h (strobe %0d) want %h", i, d, got, exp); end
      repeat (11) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturation(input logic [11:0] level);
    logic [11:0] d;
    bit got;
    do_reset();
    delay_len = 10'd1; mix_shift = 2'd0; bypass = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_sample(level, d, got);
      tests_run++;
      if (!got || d !== level) begin tests_failed++; $display("FAIL saturation_%h_out%0d got %h want %h", level, i, d, level); end
    end
  endtask

  task automatic test_fill_wrap();
    logic [11:0] d, exp;
    bit got;
    do_reset();
    delay_len = 10'd1023; mix_shift = 2'd3; bypass = 1'b0;
    for (int i = 0; i < 1026; i++) begin
      run_sample(i[11:0], d, got);
      if (i < 1023) exp = i[11:0];
      else if (i == 1023) exp = 12'h37F;
      else if (i == 1024) exp = 12'h380;
      else exp = 12'h381;
      tests_run++;
      if (!got || d !== exp) begin tests_failed++; $display("FAIL fill_wrap_out%0d got %h want %h", i, d, exp); end
    end
  endtask

  task automatic test_drop();
    int ov_count;
    logic [11:0] first;
    do_reset();
    delay_len = 10'd0; bypass = 1'b0;
    in_data = 12'h555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_data = 12'h111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ov_count = 0; first = 12'h000;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        if (ov_count == 0) first = out_data;
        ov_count++;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (ov_count != 1) begin tests_failed++; $display("FAIL drop_count got %0d want 1", ov_count); end
    tests_run++;
    if (first !== 12'h555) begin tests_failed++; $display("FAIL drop_data got %h want 555", first); end
  endtask

  task automatic test_reset_mid_mix();
    logic [11:0] d;
    bit got;
    int ov_count;
    do_reset();
    delay_len = 10'd0; bypass = 1'b0; mix_shift = 2'd0;
    run_sample(12'hC00, d, got);
    in_data = 12'h900; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    ov_count = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) ov_count++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (ov_count != 0) begin tests_failed++; $display("FAIL abort_out_valid got %0d want 0", ov_count); end
    tests_run++;
    if (out_data !== 12'h800 || busy !== 1'b0) begin tests_failed++; $display("FAIL abort_state got data=%h busy=%b want 800/0", out_data, busy); end
    delay_len = 10'd1;
    run_sample(12'h800, d, got);
    tests_run++;
    if (!got || d !== 12'h800) begin tests_failed++; $display("FAIL abort_no_echo got %h want 800", d); end
  endtask

  initial begin
    test_reset();
    test_bypass_latency();
    test_impulse();
    test_saturation(12'hFFF);
    test_saturation(12'h000);
    test_fill_wrap();
    test_drop();
    test_reset_mid_mix();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
